// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipelined opcode decoder.
//   - opcode and ALU code constants
//   - control-bundle payload struct (field order is the bundle layout)
//   - multi-cycle opcode classification helper
package ctrl_pkg;

  localparam int unsigned CTRL_OPC_W = 5;
  localparam int unsigned CTRL_ALU_W = 5;

  // Opcodes
  localparam logic [CTRL_OPC_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [CTRL_OPC_W-1:0] OP_SUB  = 5'b00001;
  localparam logic [CTRL_OPC_W-1:0] OP_MUL  = 5'b00010;
  localparam logic [CTRL_OPC_W-1:0] OP_DIV  = 5'b00011;
  localparam logic [CTRL_OPC_W-1:0] OP_MOD  = 5'b00100;
  localparam logic [CTRL_OPC_W-1:0] OP_CMP  = 5'b00101;
  localparam logic [CTRL_OPC_W-1:0] OP_AND  = 5'b00110;
  localparam logic [CTRL_OPC_W-1:0] OP_OR   = 5'b00111;
  localparam logic [CTRL_OPC_W-1:0] OP_NOT  = 5'b01000;
  localparam logic [CTRL_OPC_W-1:0] OP_MOV  = 5'b01001;
  localparam logic [CTRL_OPC_W-1:0] OP_LSL  = 5'b01010;
  localparam logic [CTRL_OPC_W-1:0] OP_LSR  = 5'b01011;
  localparam logic [CTRL_OPC_W-1:0] OP_ASR  = 5'b01100;
  localparam logic [CTRL_OPC_W-1:0] OP_NOP  = 5'b01101;
  localparam logic [CTRL_OPC_W-1:0] OP_LD   = 5'b01110;
  localparam logic [CTRL_OPC_W-1:0] OP_ST   = 5'b01111;
  localparam logic [CTRL_OPC_W-1:0] OP_BEQ  = 5'b10000;
  localparam logic [CTRL_OPC_W-1:0] OP_BGT  = 5'b10001;
  localparam logic [CTRL_OPC_W-1:0] OP_B    = 5'b10010;
  localparam logic [CTRL_OPC_W-1:0] OP_CALL = 5'b10011;
  localparam logic [CTRL_OPC_W-1:0] OP_RET  = 5'b10100;

  // ALU codes
  localparam logic [CTRL_ALU_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [CTRL_ALU_W-1:0] ALU_PASS = 5'b01101;

  // Control bundle handed to execute
  typedef struct packed {
    logic [CTRL_ALU_W-1:0] alusignal;
    logic                  isst;
    logic                  isld;
    logic                  isbeq;
    logic                  isbgt;
    logic                  isret;
    logic                  isimmediate;
    logic                  iswb;
    logic                  isubranch;
    logic                  iscall;
  } ctrl_bundle_t;

  // mul/div/mod occupy the execute unit for extra cycles
  function automatic logic is_multicycle_op(input logic [CTRL_OPC_W-1:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIV) || (opc == OP_MOD);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: pure combinational opcode table.
// Ports:
//   opcode_i        opcode field
//   i_i             immediate bit
//   imm_sign_i      sign bit of the extended immediate
//   bundle_o        decoded control bundle
//   is_multicycle_o opcode needs the mul/div/mod interlock
//   is_illegal_o    opcode outside the defined set
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [CTRL_OPC_W-1:0] opcode_i,
  input  logic                  i_i,
  input  logic                  imm_sign_i,
  output ctrl_bundle_t          bundle_o,
  output logic                  is_multicycle_o,
  output logic                  is_illegal_o
);

  // Opcode table; every flag defaults to 0
  always_comb begin
    bundle_o             = '0;
    is_illegal_o         = 1'b0;
    bundle_o.isimmediate = i_i;
    case (opcode_i)
      OP_ADD, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR,
      OP_NOT, OP_MOV, OP_LSL, OP_LSR, OP_ASR: begin
        bundle_o.alusignal = CTRL_ALU_W'(opcode_i);
        bundle_o.iswb      = 1'b1;
      end
      // Subtracting a negative immediate is issued as an add
      OP_SUB: begin
        bundle_o.alusignal = (i_i && imm_sign_i) ? ALU_ADD : CTRL_ALU_W'(opcode_i);
        bundle_o.iswb      = 1'b1;
      end
      // Compare only updates flags
      OP_CMP: bundle_o.alusignal = CTRL_ALU_W'(opcode_i);
      OP_NOP: bundle_o.alusignal = ALU_PASS;
      OP_LD: begin
        bundle_o.alusignal = ALU_ADD;
        bundle_o.isld      = 1'b1;
        bundle_o.iswb      = 1'b1;
      end
      OP_ST: begin
        bundle_o.alusignal = ALU_ADD;
        bundle_o.isst      = 1'b1;
      end
      OP_BEQ: begin
        bundle_o.alusignal = ALU_PASS;
        bundle_o.isbeq     = 1'b1;
      end
      OP_BGT: begin
        bundle_o.alusignal = ALU_PASS;
        bundle_o.isbgt     = 1'b1;
      end
      OP_B: begin
        bundle_o.alusignal = ALU_PASS;
        bundle_o.isubranch = 1'b1;
      end
      OP_CALL: begin
        bundle_o.alusignal = ALU_PASS;
        bundle_o.isubranch = 1'b1;
        bundle_o.iscall    = 1'b1;
        bundle_o.iswb      = 1'b1;
      end
      OP_RET: begin
        bundle_o.alusignal = ALU_PASS;
        bundle_o.isubranch = 1'b1;
        bundle_o.isret     = 1'b1;
      end
      // Undefined opcodes become a bubble with no flags at all
      default: begin
        bundle_o.isimmediate = 1'b0;
        is_illegal_o         = 1'b1;
      end
    endcase
  end

  assign is_multicycle_o = is_multicycle_op(opcode_i);

endmodule

// File: rtl/pipelined_control.sv
// pipelined_control: registered, handshaked control decoder between
// operand fetch and execute, with a mul/div/mod interlock and branch flush.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   in_opcode, in_i          opcode and immediate bit
//   in_imm_sign              sign of the extended immediate
//   flush                    taken branch in execute, kills held/pending work
//   out_valid/out_ready      downstream handshake
//   out_alusignal, out_is*   registered control bundle
//   busy                     multi-cycle interlock active
// Optional: define CTRL_ILLEGAL_TRAP_EN to add out_illegal and stall the
// decoder after an undefined opcode until flush or rst.
module pipelined_control
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W      = CTRL_OPC_W,
  parameter int unsigned ALU_W      = CTRL_ALU_W,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic             in_i,
  input  logic             in_imm_sign,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] out_alusignal,
  output logic             out_isst,
  output logic             out_isld,
  output logic             out_isbeq,
  output logic             out_isbgt,
  output logic             out_isret,
  output logic             out_isimmediate,
  output logic             out_iswb,
  output logic             out_isubranch,
  output logic             out_iscall,
  output logic             busy
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic             out_illegal
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [1:0] ST_TRAP = 2'd2;
`endif
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  ctrl_bundle_t     bundle_q, bundle_d;
  ctrl_bundle_t     dec_bundle;
  logic             dec_multi;
  logic             dec_illegal;
  logic             accept;

  ctrl_decode u_decode (
    .opcode_i        (CTRL_OPC_W'(in_opcode)),
    .i_i             (in_i),
    .imm_sign_i      (in_imm_sign),
    .bundle_o        (dec_bundle),
    .is_multicycle_o (dec_multi),
    .is_illegal_o    (dec_illegal)
  );

  // Accept only when idle, not flushing, and the output slot frees this cycle
  assign in_ready = (state_q == ST_IDLE) && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
`endif

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            bundle_d = dec_bundle;
            if (dec_multi) begin
              state_d = ST_WAIT;
              cnt_d   = CNT_LOAD;
            end else begin
              out_valid_d = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (dec_illegal) begin
              state_d = ST_TRAP;
            end
`endif
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        ST_TRAP: state_d = ST_TRAP;
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_WAIT);
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d = out_valid_d && (accept ? dec_illegal : illegal_q);
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      bundle_q    <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      bundle_q    <= bundle_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign out_valid       = out_valid_q;
  assign busy            = busy_q;
  assign out_alusignal   = ALU_W'(bundle_q.alusignal);
  assign out_isst        = bundle_q.isst;
  assign out_isld        = bundle_q.isld;
  assign out_isbeq       = bundle_q.isbeq;
  assign out_isbgt       = bundle_q.isbgt;
  assign out_isret       = bundle_q.isret;
  assign out_isimmediate = bundle_q.isimmediate;
  assign out_iswb        = bundle_q.iswb;
  assign out_isubranch   = bundle_q.isubranch;
  assign out_iscall      = bundle_q.iscall;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign out_illegal     = illegal_q;
`endif

endmodule

// File: tb/tb_pipelined_control.sv
// Self-checking bench for pipelined_control: directed scenarios plus a
// randomized stream, with a scoreboard queue and a negedge monitor.
module tb_pipelined_control;

  localparam int LAT = 4;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, in_i, in_imm_sign, flush, out_ready;
  logic [4:0] in_opcode;
  logic       in_ready, out_valid, busy;
  logic [4:0] out_alusignal;
  logic       out_isst, out_isld, out_isbeq, out_isbgt, out_isret;
  logic       out_isimmediate, out_iswb, out_isubranch, out_iscall;
  logic       ill_w;

  pipelined_control dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_opcode       (in_opcode),
    .in_i            (in_i),
    .in_imm_sign     (in_imm_sign),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_alusignal   (out_alusignal),
    .out_isst        (out_isst),
    .out_isld        (out_isld),
    .out_isbeq       (out_isbeq),
    .out_isbgt       (out_isbgt),
    .out_isret       (out_isret),
    .out_isimmediate (out_isimmediate),
    .out_iswb        (out_iswb),
    .out_isubranch   (out_isubranch),
    .out_iscall      (out_iscall),
    .busy            (busy)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .out_illegal     (ill_w)
`endif
  );

`ifndef CTRL_ILLEGAL_TRAP_EN
  assign ill_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [14:0] v;
    int          acc;
    int          lat;
  } sb_t;

  sb_t  q[$];
  bit   head_seen;
  bit   rnd_rdy;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [14:0] act;
  assign act = {ill_w, out_alusignal, out_isst, out_isld, out_isbeq, out_isbgt,
                out_isret, out_isimmediate, out_iswb, out_isubranch, out_iscall};

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, a, e, cyc);
    end
  endtask

  // Reference decode from the opcode rules, packed like act
  function automatic logic [14:0] model(input int op, input bit i, input bit s);
    logic [4:0] alu;
    bit         wb, ill;
    ill = (op > 20);
    if (op <= 12)                              alu = (op == 1 && i && s) ? 5'd0 : 5'(op);
    else if (op == 13 || (op >= 16 && op <= 20)) alu = 5'd13;
    else                                       alu = 5'd0;
    wb = (op <= 12 && op != 5) || op == 14 || op == 19;
    return {TRAP && ill, alu, op == 15, op == 14, op == 16, op == 17, op == 20,
            i && !ill, wb, (op >= 18 && op <= 20), op == 19};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one instruction, hold until accepted, record expectation
  task automatic issue(input int op, input bit i, input bit s, output int stalls);
    sb_t e;
    bit  got;
    got         = 1'b0;
    stalls      = 0;
    in_valid    = 1'b1;
    in_opcode   = 5'(op);
    in_i        = i;
    in_imm_sign = s;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else begin
        stalls++;
        @(posedge clk);
        #1;
      end
    end
    if (got) begin
      e.v   = model(op, i, s);
      e.acc = cyc;
      e.lat = (op >= 2 && op <= 4) ? LAT + 1 : 1;
      q.push_back(e);
    end else begin
      chk("accept_timeout", 32'(0), 32'(1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int st;
    int op;
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_i = 1'b0; in_imm_sign = 1'b0;
    flush = 1'b0; out_ready = 1'b1; rnd_rdy = 1'b0; head_seen = 1'b0;

    fork
      // Monitor: compare each presented bundle against the queue head
      forever begin
        @(negedge clk);
        if (out_valid) begin
          if (q.size() == 0) chk("spurious_out_valid", 32'(1), 32'(0));
          else begin
            if (!head_seen) begin
              chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
              head_seen = 1'b1;
            end
            chk("bundle", 32'(act), 32'(q[0].v));
            if (out_ready) begin
              void'(q.pop_front());
              head_seen = 1'b0;
            end
          end
        end
      end
      // Random downstream backpressure
      forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    chk("reset_bundle", 32'(act), 32'(0));
    @(posedge clk);
    #1;

    // Single add
    issue(0, 0, 0, st);
    // Back-to-back stream
    issue(7, 0, 0, st);  chk("stream_stall0", 32'(st), 32'(0));
    issue(14, 1, 0, st); chk("stream_stall1", 32'(st), 32'(0));
    issue(16, 0, 0, st); chk("stream_stall2", 32'(st), 32'(0));
    issue(9, 1, 1, st);  chk("stream_stall3", 32'(st), 32'(0));
    // sub with negative immediate, call, cmp, nop
    issue(1, 1, 1, st);
    issue(19, 0, 0, st);
    issue(5, 1, 0, st);
    issue(13, 0, 0, st);
    idle(2);

    // mul interlock
    issue(2, 0, 0, st);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("mul_busy", 32'(busy), 32'(1));
      chk("mul_in_ready", 32'(in_ready), 32'(0));
    end
    @(negedge clk);
    chk("mul_done_busy", 32'(busy), 32'(0));
    chk("mul_done_valid", 32'(out_valid), 32'(1));
    @(posedge clk);
    #1;
    idle(2);

    // Flush during WAIT kills the pending mul
    issue(3, 0, 0, st);
    flush = 1'b1; in_valid = 1'b1; in_opcode = 5'd0;
    @(negedge clk);
    chk("flush_blocks_accept", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    q.delete(); head_seen = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'(0));
    chk("flush_out_valid", 32'(out_valid), 32'(0));
    chk("flush_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    idle(8);

    // Backpressure with st held
    out_ready = 1'b0;
    issue(15, 0, 0, st);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'(1));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_bundle", 32'(act), 32'(model(15, 0, 0)));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_single_transfer", 32'(out_valid), 32'(0));
    chk("bp_queue_empty", 32'(q.size()), 32'(0));
    @(posedge clk);
    #1;

    // Reset mid-WAIT
    issue(4, 1, 0, st);
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); head_seen = 1'b0;
    @(negedge clk);
    chk("rst_wait_valid", 32'(out_valid), 32'(0));
    chk("rst_wait_busy", 32'(busy), 32'(0));
    chk("rst_wait_bundle", 32'(act), 32'(0));
    chk("rst_wait_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    idle(8);

    // Randomized stream with random backpressure
    rnd_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, TRAP ? 20 : 31);
      issue(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), st);
      idle($urandom_range(0, 2));
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'(0));

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Illegal opcode traps until flush
    issue(31, 1, 0, st);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("trap_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("trap_released", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
